// File: rtl/alu_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_div_seq
//  Brief    : Sequential signed divider / modulo unit. Runs one restoring
//             shift-subtract step per cycle on operand magnitudes, then
//             applies C-style signs (quotient truncates toward zero,
//             remainder takes the dividend's sign). Divide-by-zero
//             completes immediately with a flag.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             op_mod,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             dbz
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   quo_q, quo_d;     // dividend magnitude, shifted into quotient
  logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0]   dvs_q, dvs_d;     // divisor magnitude
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic               mod_q, mod_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               dbz_q, dbz_d;

  // datapath for one restoring step and operand magnitudes
  logic [WIDTH:0]     w_shifted;
  logic [WIDTH:0]     w_diff;
  logic               w_fits;
  logic [WIDTH-1:0]   w_quo_step;
  logic [WIDTH-1:0]   w_rem_step;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;

  // Next-state, datapath step and registered-output computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    mod_d    = mod_q;
    done_d   = 1'b0;
    result_d = result_q;
    dbz_d    = dbz_q;

    // Bring the next dividend bit into the remainder and try to subtract.
    w_shifted  = {rem_q, quo_q[WIDTH-1]};
    w_diff     = w_shifted - {1'b0, dvs_q};
    w_fits     = ~w_diff[WIDTH];
    w_quo_step = {quo_q[WIDTH-2:0], w_fits};
    w_rem_step = w_fits ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];

    // Most-negative operand maps to 2^(WIDTH-1), which still fits unsigned.
    w_mag_a = opa[WIDTH-1] ? (~opa + 1'b1) : opa;
    w_mag_b = opb[WIDTH-1] ? (~opb + 1'b1) : opb;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          if (opb == '0) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            dbz_d    = 1'b1;
            result_d = op_mod ? opa : '1;
          end else begin
            state_d = S_CALC;
            quo_d   = w_mag_a;
            dvs_d   = w_mag_b;
            rem_d   = '0;
            neg_a_d = opa[WIDTH-1];
            neg_b_d = opb[WIDTH-1];
            mod_d   = op_mod;
            cnt_d   = '0;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          quo_d = w_quo_step;
          rem_d = w_rem_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == C_LAST_CNT) begin
            // Final step: apply signs to the freshly computed magnitudes.
            state_d = S_DONE;
            done_d  = 1'b1;
            dbz_d   = 1'b0;
            if (mod_q) begin
              result_d = neg_a_q ? (~w_rem_step + 1'b1) : w_rem_step;
            end else begin
              result_d = (neg_a_q ^ neg_b_q) ? (~w_quo_step + 1'b1) : w_quo_step;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      mod_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      mod_q    <= mod_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign dbz    = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_div_seq
//  Brief    : Self-checking bench for alu_div_seq. A latency/arithmetic
//             reference model predicts busy/done/result/dbz every cycle;
//             directed cases pin literal results and latencies.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_div_seq;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic             op_mod;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             dbz;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  alu_div_seq #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .op_mod (op_mod),
    .opa    (opa),
    .opb    (opb),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result),
    .dbz    (dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed divide/modulo by plain 64-bit arithmetic; divide-by-zero special.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic m,
                                  output logic [31:0] r, output logic z);
    longint sa, sb, q, rr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      z = 1'b1;
      r = m ? a : 32'hFFFF_FFFF;
    end else begin
      z  = 1'b0;
      q  = sa / sb;
      rr = sa % sb;
      r  = m ? rr[31:0] : q[31:0];
    end
  endfunction

  // Model: m_left = busy cycles remaining including the current one;
  // the last busy cycle (m_left == 1) is the done cycle.
  int          m_left = 0;
  logic [31:0] m_res  = '0;
  logic        m_dbz  = 1'b0;
  logic [31:0] p_res;
  logic        p_dbz;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_left = 0;
      m_res  = '0;
      m_dbz  = 1'b0;
    end else if (m_left > 0) begin
      if (flush) begin
        m_left = 0;
      end else begin
        m_left = m_left - 1;
        if (m_left == 1) begin
          m_res = p_res;
          m_dbz = p_dbz;
        end
      end
    end else if (start && !flush) begin
      ref_div(opa, opb, op_mod, p_res, p_dbz);
      if (opb == '0) begin
        m_left = 1;
        m_res  = p_res;
        m_dbz  = p_dbz;
      end else begin
        m_left = WIDTH + 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy",   {63'd0, busy}, {63'd0, (m_left > 0)});
      chk("done",   {63'd0, done}, {63'd0, (m_left == 1)});
      chk("result", {32'd0, result}, {32'd0, m_res});
      chk("dbz",    {63'd0, dbz}, {63'd0, m_dbz});
    end
  end

  // Launch one operation from IDLE and check literal result and latency.
  // Returns positioned at the negedge of the done cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic m,
                        input logic [31:0] exp_r, input logic exp_z, input int exp_lat,
                        input string name);
    int lat;
    @(negedge clk);
    opa = a; opb = b; op_mod = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({name, "_res"}, {32'd0, result}, {32'd0, exp_r});
    chk({name, "_dbz"}, {63'd0, dbz}, {63'd0, exp_z});
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = $urandom_range(0, 20);
      4: v = -$urandom_range(1, 20);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int ndone;
    rstn = 1'b0; start = 1'b0; op_mod = 1'b0; opa = '0; opb = '0; flush = 1'b0;
    #3;
    chk("rst_busy",   {63'd0, busy}, 64'd0);
    chk("rst_done",   {63'd0, done}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_dbz",    {63'd0, dbz}, 64'd0);
    repeat (3) @(negedge clk);
    rstn   = 1'b1;
    cmp_en = 1'b1;

    // Directed arithmetic cases (first one starts right after reset release).
    run_op(32'd100,        32'd7,          1'b0, 32'h0000_000E, 1'b0, 33, "div_100_7");
    run_op(32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFFE, 1'b0, 33, "mod_m100_7");
    run_op(32'hFFFF_FF9C,  32'd7,          1'b0, 32'hFFFF_FFF2, 1'b0, 33, "div_m100_7");
    run_op(32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF, 1'b1, 1,  "div_by_0");
    run_op(32'd5,          32'd0,          1'b1, 32'h0000_0005, 1'b1, 1,  "mod_by_0");
    run_op(32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000, 1'b0, 33, "div_ovf");
    run_op(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h0000_0000, 1'b0, 33, "mod_ovf");
    run_op(32'd100,        32'd7,          1'b0, 32'h0000_000E, 1'b0, 33, "div_100_7b");

    // Flush at cycle 10, with an extra start while busy that must be ignored.
    @(negedge clk);
    opa = 32'd1000; opb = 32'd3; op_mod = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    opa = 32'd9; opb = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy",   {63'd0, busy}, 64'd0);
    chk("flush_result", {32'd0, result}, 64'h0000_000E);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("flush_no_done", 64'(ndone), 64'd0);

    // Start held through the DONE cycle is ignored there, accepted in IDLE.
    run_op(32'd20, 32'd6, 1'b1, 32'h0000_0002, 1'b0, 33, "mod_20_6");
    opa = 32'd77; opb = 32'hFFFF_FFFB; op_mod = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("done_start_ignored", {63'd0, busy}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    chk("idle_start_taken", {63'd0, busy}, 64'd1);
    ndone = 0;
    while (!done && ndone < 100) begin
      @(negedge clk);
      ndone++;
    end
    chk("div_77_m5", {32'd0, result}, 64'hFFFF_FFF1);

    // Reset 15 cycles into CALC: outputs clear immediately, no done afterwards.
    @(negedge clk);
    @(negedge clk);
    opa = 32'd12345; opb = 32'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy",   {63'd0, busy}, 64'd0);
    chk("arst_done",   {63'd0, done}, 64'd0);
    chk("arst_result", {32'd0, result}, 64'd0);
    chk("arst_dbz",    {63'd0, dbz}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("arst_no_done", 64'(ndone), 64'd0);

    // Randomized traffic: starts, flushes and operand churn every cycle.
    repeat (3000) begin
      @(negedge clk);
      start  = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 99) == 0);
      op_mod = $urandom_range(0, 1);
      opa    = pick();
      opb    = pick();
    end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    repeat (40) @(negedge clk);
    cmp_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_div_seq.md
ALU_DIV_SEQ -- requirements
Module: alu_div_seq

Interface
REQ-001: The block SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002: The block SHALL have parameter CNT_W, default 5, iteration counter width, equal to log2(WIDTH).
REQ-003: Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004: Port rstn  input  1  reset; asynchronous assertion, active-low.
REQ-005: Port start  input  1  request a new divide; sampled only in IDLE.
REQ-006: Port op_mod  input  1  operation select: 0 = div (quotient), 1 = mod (remainder); captured with start.
REQ-007: Port opa  input  WIDTH  signed dividend; captured with start.
REQ-008: Port opb  input  WIDTH  signed divisor; captured with start.
REQ-009: Port flush  input  1  synchronous cancel of any operation in flight.
REQ-010: Port busy  output  1  high whenever the state is not IDLE; the pipeline stalls on it.
REQ-011: Port done  output  1  one-cycle pulse marking result valid.
REQ-012: Port result  output  WIDTH  quotient or remainder; holds its value until the next done.
REQ-013: Port dbz  output  1  divide-by-zero flag, valid with done, held with result.

Function
REQ-014: The FSM SHALL have the states IDLE, CALC and DONE; busy SHALL be high in CALC and DONE.
REQ-015: IDLE + start=1 + opb!=0 -> CALC: latch operand magnitudes, signs and op_mod; clear counter.
REQ-016: IDLE + start=1 + opb==0 -> DONE directly, with no CALC cycles.
REQ-017: CALC SHALL perform one restoring shift-subtract step per cycle on unsigned magnitudes and increment the counter.
REQ-018: After WIDTH CALC cycles (counter == WIDTH-1) the FSM SHALL go to DONE; DONE -> IDLE unconditionally.
REQ-019: Latency: start sampled at edge E0 gives done=1 in the cycle after edge E0+WIDTH+1 (33 edges for WIDTH=32), for exactly one cycle.
REQ-020: Divide-by-zero latency: done=1 in the cycle after edge E0+1.
REQ-021: Quotient SHALL truncate toward zero; its sign = sign(opa) XOR sign(opb).
REQ-022: Remainder sign SHALL equal sign(opa), with |rem| < |opb|.
REQ-023: Overflow case -2^(WIDTH-1) / -1 SHALL give div = 0x80000000 and mod = 0, with dbz=0.
REQ-024: Divide by zero SHALL give dbz=1; div result = all ones (0xFFFFFFFF); mod result = opa.
REQ-025: result and dbz SHALL update only on the edge entering the done cycle, and hold otherwise.
REQ-026: start while busy=1 SHALL be ignored; no queuing.
REQ-027: start in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-028: flush=1 in CALC or DONE SHALL force IDLE at the next edge, with no done pulse and result/dbz unchanged.
REQ-029: flush has priority over start when both are high in IDLE: stay IDLE.
REQ-030: Operands SHALL be internal registers, so input changes after capture do not affect the operation.

Reset
REQ-031: rstn=0 SHALL immediately set state=IDLE, counter=0, busy=0, done=0, result=0, dbz=0, and clear all internal operand registers.
REQ-032: Reset asserted mid-CALC SHALL abort the operation; no done SHALL follow deassertion.
REQ-033: The first start SHALL be accepted on the first edge after rstn rises.

Verification
REQ-034: opa=100, opb=7, op_mod=0 -> busy for 33 cycles; done pulse; result=0x0000000E, dbz=0.
REQ-035: opa=-100 (0xFFFFFF9C), opb=7, op_mod=1 -> result=0xFFFFFFFE (-2); same op_mod=0 -> 0xFFFFFFF2 (-14).
REQ-036: opa=5, opb=0, op_mod=0 -> done in 2nd cycle, result=0xFFFFFFFF, dbz=1; op_mod=1 -> result=5.
REQ-037: opa=0x80000000, opb=0xFFFFFFFF, op_mod=0 -> result=0x80000000; op_mod=1 -> result=0.
REQ-038: start, then flush at cycle 10 -> busy=0 next cycle, no done, result holds its previous value; second start while busy is ignored.
REQ-039: rstn low at cycle 15 of CALC -> all outputs 0 immediately; no done within 40 cycles after release without a new start.
